// File: rtl/controller_reader.sv
// rtl/controller_reader.sv - NES-style pad poller: latch/clock pins, serial sampling, stable button vector
// Optional build macro: CTRL_DEBOUNCE_EN (commit a frame only when it matches the previous raw frame)
module controller_reader #(
   parameter int CLK_DIV     = 300,
   parameter int POLL_PERIOD = 833333
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ctrl_data,
   output logic       ctrl_latch,
   output logic       ctrl_clk,
   output logic [7:0] buttons,
   output logic       valid
);

   localparam int POLL_W = $clog2(POLL_PERIOD);
   localparam int DIV_W  = $clog2(2 * CLK_DIV);

   localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);
   localparam logic [DIV_W-1:0]  LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  HALF_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE    = DIV_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_SHIFT_HI,
      S_SHIFT_LO,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        sync_q;
   logic              data_s;
   logic [POLL_W-1:0] poll_q, poll_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        raw_q, raw_d;
   logic [7:0]        buttons_q, buttons_d;
   logic              valid_q, valid_d;
   logic              latch_q, clk_q;
   logic [7:0]        mapped;
`ifdef CTRL_DEBOUNCE_EN
   logic [7:0]        prev_q, prev_d;
`endif

   // raw_q holds bits in serial order (A, B, Select, Start, Up, Down, Left, Right);
   // this reorders them into {Select, Start, B, A, Right, Left, Down, Up}.
   assign mapped = {raw_q[2], raw_q[3], raw_q[1], raw_q[0],
                    raw_q[7], raw_q[6], raw_q[5], raw_q[4]};

   assign data_s = sync_q[1];

   // Two-flop synchronizer for the pad's asynchronous data pin; resets to released (1).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], ctrl_data};
      end
   end

   // Free-running poll counter; next value wraps at the end of the poll period.
   always_comb begin
      poll_d = poll_q + POLL_W'(1);
      if (poll_q == POLL_LAST) begin
         poll_d = '0;
      end
   end

   // Poll counter register; reset parks it on the last count so a frame starts right after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         poll_q <= POLL_LAST;
      end else begin
         poll_q <= poll_d;
      end
   end

   // Next-state logic: pin phase timing, serial sampling and frame commit.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q + DIV_ONE;
      idx_d     = idx_q;
      raw_d     = raw_q;
      buttons_d = buttons_q;
      valid_d   = 1'b0;
`ifdef CTRL_DEBOUNCE_EN
      prev_d    = prev_q;
`endif
      case (state_q)
         S_IDLE: begin
            div_d = '0;
            if (poll_q == POLL_LAST) begin
               state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            // The pad presents A while latched; sample it on the last latch cycle.
            if (div_q == LATCH_LAST) begin
               raw_d[0] = ~data_s;
               idx_d    = 3'd1;
               div_d    = '0;
               state_d  = S_SHIFT_HI;
            end
         end
         S_SHIFT_HI: begin
            if (div_q == HALF_LAST) begin
               div_d   = '0;
               state_d = S_SHIFT_LO;
            end
         end
         S_SHIFT_LO: begin
            // Sample late in the low phase, well after the pad shifted on the rising edge.
            if (div_q == HALF_LAST) begin
               raw_d[idx_q] = ~data_s;
               div_d        = '0;
               if (idx_q == 3'd7) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_SHIFT_HI;
               end
            end
         end
         S_DONE: begin
            div_d   = '0;
            state_d = S_IDLE;
`ifdef CTRL_DEBOUNCE_EN
            // Only a frame that repeats the previous one reaches the outputs.
            prev_d = raw_q;
            if (raw_q == prev_q) begin
               buttons_d = mapped;
               valid_d   = 1'b1;
            end
`else
            buttons_d = mapped;
            valid_d   = 1'b1;
`endif
         end
         default: begin
            div_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State, sequencing and output registers; pin outputs are decoded from the next state so they are flop outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         idx_q     <= '0;
         raw_q     <= '0;
         buttons_q <= '0;
         valid_q   <= 1'b0;
         latch_q   <= 1'b0;
         clk_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         idx_q     <= idx_d;
         raw_q     <= raw_d;
         buttons_q <= buttons_d;
         valid_q   <= valid_d;
         latch_q   <= (state_d == S_LATCH);
         clk_q     <= (state_d == S_SHIFT_HI);
      end
   end

`ifdef CTRL_DEBOUNCE_EN
   // Previous raw frame, kept for the match test in DONE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_q <= '0;
      end else begin
         prev_q <= prev_d;
      end
   end
`endif

   assign ctrl_latch = latch_q;
   assign ctrl_clk   = clk_q;
   assign buttons    = buttons_q;
   assign valid      = valid_q;

endmodule

// File: tb/tb_controller_reader.sv
// tb/tb_controller_reader.sv - self-checking bench for controller_reader with pad model and reference model
module tb_controller_reader;

   localparam int CD = 4;
   localparam int PP = 200;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ctrl_data;
   logic       ctrl_latch;
   logic       ctrl_clk;
   logic [7:0] buttons;
   logic       valid;

   int n_total = 0;
   int n_pass  = 0;

   controller_reader #(.CLK_DIV(CD), .POLL_PERIOD(PP)) dut (
      .clock      (clock),
      .reset      (reset),
      .ctrl_data  (ctrl_data),
      .ctrl_latch (ctrl_latch),
      .ctrl_clk   (ctrl_clk),
      .buttons    (buttons),
      .valid      (valid)
   );

   always #5 clock = ~clock;

   // Pad model: pad_ser bit i is the i-th button shifted out (A, B, Select, Start, Up, Down, Left, Right), 1 = pressed.
   logic [7:0] pad_ser = 8'h00;
   logic [3:0] pad_idx = 4'd0;
   always @(posedge ctrl_clk or posedge ctrl_latch) begin
      if (ctrl_latch) pad_idx <= 4'd0;
      else if (pad_idx < 4'd8) pad_idx <= pad_idx + 4'd1;
   end
   assign ctrl_data = (pad_idx < 4'd8) ? ~pad_ser[pad_idx[2:0]] : 1'b1;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: where each serially shifted button lands in the output vector.
   int pos[8] = '{4, 5, 7, 6, 0, 1, 2, 3};
   logic [7:0] m_btn  = 8'h00;
   logic [7:0] m_prev = 8'h00;
   bit         m_valid;

   function automatic logic [7:0] ser_to_btn(input logic [7:0] s);
      logic [7:0] b = 8'h00;
      for (int i = 0; i < 8; i++) b[pos[i]] = s[i];
      return b;
   endfunction

   task automatic model_frame(input logic [7:0] s);
      logic [7:0] b = ser_to_btn(s);
`ifdef CTRL_DEBOUNCE_EN
      m_valid = (b == m_prev);
      if (m_valid) m_btn = b;
      m_prev = b;
`else
      m_valid = 1'b1;
      m_btn   = b;
`endif
   endtask

   task automatic model_reset();
      m_btn  = 8'h00;
      m_prev = 8'h00;
   endtask

   // Runs one frame with the pad holding s; checks valid presence, latency, value and pulse width.
   task automatic do_frame(input logic [7:0] s, input string tag, output bit seen);
      int n = 0;
      pad_ser = s;
      model_frame(s);
      seen = 1'b0;
      while (!ctrl_latch && n < PP + 10) begin
         @(negedge clock);
         n++;
      end
      if (!ctrl_latch) begin
         check({tag, "_frame_start_timeout"}, 0, 1);
         return;
      end
      n = 0;
      while (n < 70 && !seen) begin
         @(negedge clock);
         n++;
         if (valid) seen = 1'b1;
      end
      check({tag, "_valid_seen"}, int'(seen), int'(m_valid));
      if (seen) check({tag, "_valid_latency"}, n, 16 * CD + 1);
      check({tag, "_buttons"}, int'(buttons), int'(m_btn));
      @(negedge clock);
      check({tag, "_valid_one_cycle"}, int'(valid), 0);
   endtask

   // Waveform monitor: latch width, clock phases, pulse count, frame spacing, no overlap.
   int cyc = 0, last_rise = -1, pulses = 0, lat_run = 0, hi_run = 0, lo_run = 0;
   logic pl = 1'b0, pc = 1'b0;
   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         last_rise = -1; pulses = 0; lat_run = 0; hi_run = 0; lo_run = 0;
         pl = 1'b0; pc = 1'b0;
      end else begin
         if (ctrl_latch || ctrl_clk) check("latch_clk_overlap", int'(ctrl_latch & ctrl_clk), 0);
         if (ctrl_latch && !pl) begin
            if (last_rise >= 0) begin
               check("latch_spacing", cyc - last_rise, PP);
               check("clk_pulses_per_frame", pulses, 7);
            end
            last_rise = cyc;
            pulses    = 0;
         end
         if (ctrl_latch) lat_run++;
         if (!ctrl_latch && pl) begin
            check("latch_width", lat_run, 2 * CD);
            lat_run = 0;
         end
         if (ctrl_clk && !pc) begin
            pulses++;
            if (pulses > 1) check("clk_low_width", lo_run, CD);
            hi_run = 0;
         end
         if (ctrl_clk) hi_run++;
         if (!ctrl_clk && pc) begin
            check("clk_high_width", hi_run, CD);
            lo_run = 0;
         end
         if (!ctrl_clk) lo_run++;
         pl = ctrl_latch;
         pc = ctrl_clk;
      end
   end

   typedef struct {
      logic [7:0] ser;
      logic [7:0] exp;
   } vec_t;

   initial begin
      vec_t tbl[11];
      bit   seen;
      int   k;
      logic [7:0] deb_ser[4];
      logic [7:0] deb_exp[4];
      bit         deb_val[4];

      tbl[0]  = '{8'h62, 8'h26};   // B + Down + Left
      tbl[1]  = '{8'h00, 8'h00};   // all released
      tbl[2]  = '{8'hFF, 8'hFF};   // all pressed
      tbl[3]  = '{8'h01, 8'h10};   // A
      tbl[4]  = '{8'h02, 8'h20};   // B
      tbl[5]  = '{8'h04, 8'h80};   // Select
      tbl[6]  = '{8'h08, 8'h40};   // Start
      tbl[7]  = '{8'h10, 8'h01};   // Up
      tbl[8]  = '{8'h20, 8'h02};   // Down
      tbl[9]  = '{8'h40, 8'h04};   // Left
      tbl[10] = '{8'h80, 8'h08};   // Right

      deb_ser = '{8'h62, 8'h62, 8'h01, 8'h01};
`ifdef CTRL_DEBOUNCE_EN
      deb_exp = '{8'h00, 8'h26, 8'h26, 8'h10};
      deb_val = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      deb_exp = '{8'h26, 8'h26, 8'h10, 8'h10};
      deb_val = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

      // Reset state
      pad_ser = tbl[0].ser;
      repeat (3) @(negedge clock);
      check("rst_latch", int'(ctrl_latch), 0);
      check("rst_clk", int'(ctrl_clk), 0);
      check("rst_buttons", int'(buttons), 0);
      check("rst_valid", int'(valid), 0);
      reset = 1'b0;

      // Table: each pattern held for two frames, then the settled value is compared.
      for (int i = 0; i < 11; i++) begin
         do_frame(tbl[i].ser, $sformatf("tbl%0d_a", i), seen);
         do_frame(tbl[i].ser, $sformatf("tbl%0d_b", i), seen);
         check($sformatf("tbl%0d_settled", i), int'(buttons), int'(tbl[i].exp));
      end

      // Randomized frames against the model
      for (int i = 0; i < 12; i++) begin
         do_frame(8'($urandom), $sformatf("rnd%0d", i), seen);
      end

      // Mid-frame reset during the 4th ctrl_clk pulse
      do_frame(8'h62, "pre_rst_a", seen);
      do_frame(8'h62, "pre_rst_b", seen);
      pad_ser = 8'h9C;
      k = 0;
      while (!ctrl_latch && k < PP + 10) begin @(negedge clock); k++; end
      k = 0;
      begin
         int rises = 0;
         logic prev_c = 1'b0;
         while (rises < 4 && k < 100) begin
            @(negedge clock);
            k++;
            if (ctrl_clk && !prev_c) rises++;
            prev_c = ctrl_clk;
         end
         check("midrst_reached_4th_pulse", rises, 4);
      end
      #3 reset = 1'b1;
      #1;
      check("midrst_clk", int'(ctrl_clk), 0);
      check("midrst_latch", int'(ctrl_latch), 0);
      check("midrst_buttons", int'(buttons), 0);
      check("midrst_valid", int'(valid), 0);
      repeat (3) @(negedge clock);
      model_reset();
      reset = 1'b0;
      do_frame(8'h9C, "post_rst_a", seen);
      do_frame(8'h9C, "post_rst_b", seen);
      check("post_rst_settled", int'(buttons), int'(ser_to_btn(8'h9C)));

      // Debounce sequence from a fresh reset
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      model_reset();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         do_frame(deb_ser[i], $sformatf("deb%0d", i), seen);
         check($sformatf("deb%0d_const_buttons", i), int'(buttons), int'(deb_exp[i]));
         check($sformatf("deb%0d_const_valid", i), int'(seen), int'(deb_val[i]));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
